// File: rtl/timer_bank_pkg.sv
// Shared definitions for the three-channel timer bank: channel state encoding,
// default timing constants and counter width helpers.
package timer_bank_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chan_state_e;

   localparam int DEFAULT_PRESCALE = 12000;
   localparam int DEFAULT_T0_TICKS = 250;
   localparam int DEFAULT_T1_TICKS = 250;
   localparam int DEFAULT_T2_TICKS = 1000;

   // A zero count is treated as one.
   function automatic int at_least_one(input int x);
      return (x < 1) ? 1 : x;
   endfunction

   function automatic int width_of(input int x);
      int w;
      w = $clog2(x);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One-shot timer channel: arms on a start level, expires after PRESCALE*TICKS cycles.
// Periodic reload while start is held is enabled by TIMER_BANK_RELOAD_EN.
module timer_channel
   import timer_bank_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE,
   parameter int TICKS    = DEFAULT_T0_TICKS
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   output logic intr,
   output logic busy
);

   localparam int PRE_EFF = at_least_one(PRESCALE);
   localparam int CNT_EFF = at_least_one(TICKS);
   localparam int PRE_W   = width_of(PRE_EFF);
   localparam int CNT_W   = width_of(CNT_EFF);
   localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRE_EFF - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_EFF - 1);

   chan_state_e      state, state_next;
   logic [PRE_W-1:0] pre, pre_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             intr_next;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_next = state;
      pre_next   = pre;
      cnt_next   = cnt;
      intr_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               pre_next   = PRE_LOAD;
               cnt_next   = CNT_LOAD;
            end
         end
         RUN: begin
            if (!start) begin
               state_next = IDLE;
               pre_next   = '0;
               cnt_next   = '0;
            end else if (pre != '0) begin
               pre_next = pre - 1'b1;
            end else if (cnt != '0) begin
               pre_next = PRE_LOAD;
               cnt_next = cnt - 1'b1;
            end else begin
               intr_next = 1'b1;
`ifdef TIMER_BANK_RELOAD_EN
               // Reload in place so the period stays exactly N with busy held high.
               pre_next = PRE_LOAD;
               cnt_next = CNT_LOAD;
`else
               state_next = DONE;
`endif
            end
         end
         DONE: begin
            if (!start) begin
               state_next = IDLE;
            end else begin
`ifdef TIMER_BANK_RELOAD_EN
               state_next = RUN;
               pre_next   = PRE_LOAD;
               cnt_next   = CNT_LOAD;
`endif
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pre   <= '0;
         cnt   <= '0;
         intr  <= 1'b0;
      end else begin
         state <= state_next;
         pre   <= pre_next;
         cnt   <= cnt_next;
         intr  <= intr_next;
      end
   end

   assign busy = (state == RUN);

endmodule

// File: rtl/timer_bank.sv
// Three independent timer channels (OFF, ON, IDLE times) for the LED sequencer.
// Optional periodic reload while start is held: define TIMER_BANK_RELOAD_EN.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE,
   parameter int T0_TICKS = DEFAULT_T0_TICKS,
   parameter int T1_TICKS = DEFAULT_T1_TICKS,
   parameter int T2_TICKS = DEFAULT_T2_TICKS
) (
   input  logic       clock_in,
   input  logic       reset_in,
   input  logic       t0_start_in,
   input  logic       t1_start_in,
   input  logic       t2_start_in,
   output logic       t0_int_out,
   output logic       t1_int_out,
   output logic       t2_int_out,
   output logic [2:0] busy_out
);

   logic busy0, busy1, busy2;

   timer_channel #(.PRESCALE(PRESCALE), .TICKS(T0_TICKS)) u_ch0 (
      .clock (clock_in),
      .reset (reset_in),
      .start (t0_start_in),
      .intr  (t0_int_out),
      .busy  (busy0)
   );

   timer_channel #(.PRESCALE(PRESCALE), .TICKS(T1_TICKS)) u_ch1 (
      .clock (clock_in),
      .reset (reset_in),
      .start (t1_start_in),
      .intr  (t1_int_out),
      .busy  (busy1)
   );

   timer_channel #(.PRESCALE(PRESCALE), .TICKS(T2_TICKS)) u_ch2 (
      .clock (clock_in),
      .reset (reset_in),
      .start (t2_start_in),
      .intr  (t2_int_out),
      .busy  (busy2)
   );

   assign busy_out = {busy2, busy1, busy0};

endmodule

// File: doc/timer_bank.md
# timer_bank

Three-channel one-shot timer that answers the LED sequencer's timer handshake. Each channel arms on its `tN_start_in` level, counts a fixed number of prescaled ticks and returns a single-cycle `tN_int_out` pulse. The bank sits beside the sequencer: channel 0 sets OFF time, channel 1 sets ON time, channel 2 sets IDLE time.

## Interface
- `PRESCALE`, 12000: clock cycles per tick, ≥1; 0 is treated as 1.
- `T0_TICKS`, 250: channel 0 period in ticks, ≥1; 0 is treated as 1.
- `T1_TICKS`, 250: channel 1 period in ticks, ≥1; 0 is treated as 1.
- `T2_TICKS`, 1000: channel 2 period in ticks, ≥1; 0 is treated as 1.
- `clock_in` in 1: the single clock; all logic is on the rising edge.
- `reset_in` in 1: asynchronous, active-high reset.
- `t0_start_in`, `t1_start_in`, `t2_start_in` in 1 each: arm request, level, held by the sequencer.
- `t0_int_out`, `t1_int_out`, `t2_int_out` out 1 each: expiry pulse, one cycle, registered.
- `busy_out` out 3: bit N is high while channel N is in RUN.

## Operation
- The channels are independent and identical, differing only in `TICKS`. `N = PRESCALE*TICKS`.
- Each channel has three states: IDLE, RUN and DONE.
- IDLE, `start=1` sampled: go to RUN, load `pre=PRESCALE-1` and `cnt=TICKS-1`.
- IDLE, `start=0`: stay in IDLE.
- RUN, `start=0` sampled: abort to IDLE. No int is produced, and the abort wins over a simultaneous terminal count.
- RUN, `pre>0`: decrement `pre`.
- RUN, `pre==0` and `cnt>0`: reload `pre=PRESCALE-1` and decrement `cnt`.
- RUN, `pre==0` and `cnt==0` (terminal): go to DONE and assert `int_out` for exactly one cycle.
- DONE, `start=0`: go to IDLE.
- DONE, `start=1`: behaviour is set by the configuration macro (see Configuration).
- Counters are unsigned. `pre` is `$clog2(PRESCALE)` bits and `cnt` is `$clog2(TICKS)` bits, each with a minimum of 1 bit. Counters never wrap below 0.
- Reset, including reset asserted mid-RUN, forces every channel to IDLE and clears the counters. No int is produced for the aborted run.

## Timing
- Reset values: all `tN_int_out` = 0, `busy_out` = 3'b000, all channels in IDLE.
- Let edge E0 be the edge that samples `start=1` in IDLE.
  - `busy` is high from E0 to E0+N.
  - `int_out` rises at edge E0+N and falls at E0+N+1.
- Start-to-int latency is exactly N cycles, with no jitter, because the prescaler restarts on every arm.
- The sequencer drops `start` on the edge after it sees `int`. Because the channel is in DONE at that point, it re-enters IDLE and does not re-arm.
- Minimum re-arm gap: after `start` is seen low in DONE (→IDLE), a new `start=1` arms on the next edge.
- `int_out` is never high for more than one consecutive cycle, except in reload mode when N=1.

## Configuration
- Macro: `TIMER_BANK_RELOAD_EN`.
- Defined: DONE with `start=1` reloads the counters exactly as an arm from IDLE does and re-enters RUN. `busy` stays high, which yields periodic int pulses every N cycles while `start` is held.
- Undefined (one-shot): DONE with `start=1` stays in DONE with `busy=0` until `start` falls. A held start produces exactly one pulse.

## Structure
- The shared package `timer_bank_pkg` holds:
  - the channel state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the default `PRESCALE` and `TICKS` constants;
  - a width function `max(1,$clog2(x))`.
- Sub-module `timer_channel` has parameters `PRESCALE` and `TICKS`, and ports clock, reset, start, int and busy. `timer_bank` instantiates it three times and concatenates the busy bits.

## Test plan
Bench parameters: `PRESCALE=4`, `T0_TICKS=3`, `T1_TICKS=5`, `T2_TICKS=2` (N0=12, N1=20, N2=8).
1. Release reset, then hold `t1_start_in=1` from edge E0 → `busy_out[1]` is high for 20 cycles, and `t1_int_out` is high only in the cycle after E0+20. Outputs are 0 during reset.
2. Drop `t0_start_in` at E0+11, one edge before terminal count → no `t0_int_out`, and the channel returns to IDLE. A new arm gives int 12 cycles later.
3. Arm all three channels on the same edge → ints at E0+8 (ch2), E0+12 (ch0) and E0+20 (ch1), each one cycle wide.
4. Assert `reset_in` asynchronously mid-run on ch1 (E0+10) → `busy_out` and int are 0 immediately, and no int fires after reset is released.
5. Hold `t2_start_in` for 40 cycles:
   - with `TIMER_BANK_RELOAD_EN` defined → pulses at E0+8, 16, 24, 32 and 40;
   - without it → a single pulse at E0+8, then `busy=0` until start falls.
6. Build with `PRESCALE=1`, `TICKS=1` → int rises exactly 1 cycle after arm.
